// File: rtl/wbt_pkg.sv
// Shared types and widths for the write-back trace buffer.
package wbt_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ENTRY_W = PC_W + ADDR_W + DATA_W;
    localparam int unsigned DROP_W  = 8;

    // One captured retirement: PC tag, destination register, result value.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbt_entry_t;

    // Capture state: RUN accepts pushes, FROZEN holds contents until clear.
    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } wbt_state_e;

    // Saturating increment for the dropped-capture counter.
    function automatic logic [DROP_W-1:0] drop_sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/wbt_fifo_mem.sv
// Trace storage: one synchronous write port, one asynchronous read port.
module wbt_fifo_mem
    import wbt_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  wbt_entry_t               wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output wbt_entry_t               rd_data
);

    wbt_entry_t mem [DEPTH];

    // Array contents are intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: captures register writes into a FWFT FIFO with
// overflow tracking and optional freeze-on-overflow.
module wb_trace_buffer
    import wbt_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter bit          STOP_ON_OVF = 1'b0
) (
    input  logic                     clk_CPU,
    input  logic                     rst_n_CPU,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     regWrite_in,
    input  logic [ADDR_W-1:0]        wAddr_in,
    input  logic [DATA_W-1:0]        wData_in,
    input  logic [PC_W-1:0]          pc_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              valid_q, valid_d;
    wbt_entry_t        head_q, head_d;
    wbt_state_e        state_q, state_d;

    logic              push_req;
    logic              push;
    logic              pop;
    logic              drop;
    logic              full;
    logic              mem_wr_en;
    logic [PTR_W-1:0]  next_rd_addr;
    wbt_entry_t        in_entry;
    wbt_entry_t        next_entry;

    // The memory is read one slot ahead so the head register can be refilled on a pop.
    wbt_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk_CPU),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (in_entry),
        .rd_addr (next_rd_addr),
        .rd_data (next_entry)
    );

    // Push/pop/drop qualification; register 0 writes are never traced.
    always_comb begin
        in_entry      = '{pc: pc_in, addr: wAddr_in, data: wData_in};
        next_rd_addr  = rd_ptr_q + PTR_W'(1);
        full          = (count_q == CNT_W'(DEPTH));
        push_req      = enable & regWrite_in & (wAddr_in != '0) & (state_q == RUN);
        pop           = valid_q & out_ready;
        push          = push_req & (~full | pop);
        drop          = push_req & full & ~pop;
        mem_wr_en     = push & ~clear;
    end

    // Next-state for pointers, occupancy, overflow tracking, capture state and head entry.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        state_d  = state_q;
        head_d   = head_q;
        valid_d  = valid_q;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            drop_d   = '0;
            state_d  = RUN;
            head_d   = '0;
            valid_d  = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = next_rd_addr;
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase

            if (drop) begin
                ovf_d  = 1'b1;
                drop_d = drop_sat_inc(drop_q);
                if (STOP_ON_OVF) begin
                    state_d = FROZEN;
                end
            end

            // Head refill: next stored entry, else the incoming one when the FIFO drains/was empty.
            if (pop) begin
                if (count_q > CNT_W'(1)) begin
                    head_d = next_entry;
                end else if (push) begin
                    head_d = in_entry;
                end
            end else if ((count_q == '0) && push) begin
                head_d = in_entry;
            end

            valid_d = (count_d != '0);
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_CPU) begin
        if (!rst_n_CPU) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            state_q  <= RUN;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            state_q  <= state_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = head_q.pc;
    assign out_addr  = head_q.addr;
    assign out_data  = head_q.data;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;

endmodule
